uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
- Buffered UART transmitter sitting directly downstream of the memory-mapped UART write port: consumes the byte and write strobe that mem produces on a store to the UART address.
- Queues bytes in a FIFO so back-to-back CPU stores are not lost while a frame is on the wire.
- Serializes 8N1 frames (optional parity) on tx using a baud divider derived from the single system clock, so no separate baud clock is needed.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate.
- DEPTH, 16, FIFO entries; must be a power of 2, minimum 2.
- DIV (localparam), CLK_HZ/BAUD rounded to nearest integer, clk cycles per bit; must be at least 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- wen  in  1  write strobe from mem (uart_tx_wen).
- wdata  in  8  byte to send (uart_tx_data).
- full  out  1  FIFO holds DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky; a write was dropped.
- busy  out  1  a frame is in progress (state != IDLE).
- tx  out  1  serial line, idle high.

Behaviour:
- Reset (reset==0 at a clk edge):
  - tx=1, busy=0, full=0, empty=1, level=0, overflow=0.
  - Read and write pointers cleared; serializer forced to IDLE.
  - Reset mid-frame aborts the frame: tx is 1 from the next cycle, and queued bytes are discarded.
- All outputs are registered except full, empty and busy, which decode registered state.
- FIFO write:
  - A byte is accepted when wen=1 and full=0, based on the registered level.
  - When wen=1 and full=1, the byte is dropped, overflow is set to 1 and held until reset. This applies even if a pop occurs in the same cycle.
- FIFO pop: occurs when the serializer is in IDLE and empty=0. The head byte is loaded into the shift register.
- level update:
  - +1 on accept only; -1 on pop only; unchanged if both or neither.
  - Pointers wrap modulo DEPTH.
- Serializer FSM (bit counter 0..DIV-1, bit index 0..7):
  - IDLE: tx=1. If !empty, pop, go to START, clear the bit counter.
  - START: tx=0 for DIV cycles, then go to DATA with index 0.
  - DATA: tx=shift[0], LSB first, for DIV cycles per bit. After bit 7, go to STOP (or PARITY when enabled).
  - STOP: tx=1 for DIV cycles, then go to IDLE.
  - Queued bytes are sent back-to-back: exactly one IDLE cycle between a stop bit and the next start bit.
- Latency on an empty, idle queue: wen at edge N; pop at edge N+1; tx=0 from edge N+2, lasting DIV cycles.
- Frame length: 10*DIV cycles for 8N1, 11*DIV with parity, plus 1 IDLE cycle between frames.
- A write to an empty FIFO while a frame is active is accepted normally; the pop waits for IDLE.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- When defined: a PARITY state is inserted after DATA and before STOP. tx = XOR of the 8 data bits (even parity) for DIV cycles.
- When undefined: no PARITY state and no parity logic; the frame is 8N1.

Test Plan:
- Single byte, CLK_HZ=8, BAUD=1 (DIV=8): wen with 0x55 -> tx low from cycle 2 for 8 cycles, then bits 1,0,1,0,1,0,1,0 at 8 cycles each, then high 8 cycles; busy high for 80 cycles; level back to 0 after the pop.
- Burst of 3 writes (0x01, 0x02, 0x03) on consecutive cycles -> level peaks at 2; three back-to-back frames, each followed by exactly 1 idle cycle; decoded bytes are 0x01, 0x02, 0x03 in order.
- Overflow, DEPTH=4, with the first frame in flight: 6 writes 0xA0..0xA5 -> 0xA0 is popped and in flight, 0xA1..0xA4 are queued, full=1, 0xA5 is dropped, overflow=1 and stays 1 after the queue drains; 5 bytes transmitted.
- Reset mid-frame: assert reset during data bit 3 with 2 bytes queued -> next cycle tx=1, level=0, busy=0; no further frames without new writes.
- Simultaneous push/pop: level=1, IDLE, wen same cycle as pop -> level remains 1 and the new byte is sent next.
- UART_TX_PARITY_EN defined: send 0x07 -> parity bit = 1 and frame is 11*DIV cycles; send 0x03 -> parity bit = 0.

Source files
------------

// File: rtl/uart_tx_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_queue_if
// Purpose  : Write-port and status bundle between the CPU store path and the
//            buffered UART transmitter.
// Revision : 1.0  initial release
// ============================================================================
interface uart_tx_queue_if #(
    parameter int DEPTH = 16
);
    logic                     wen;
    logic [7:0]               wdata;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic                     busy;
    logic                     tx;

    modport master (
        output wen, wdata,
        input  full, empty, level, overflow, busy, tx
    );

    modport slave (
        input  wen, wdata,
        output full, empty, level, overflow, busy, tx
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_queue
// Purpose  : FIFO-buffered 8N1 UART transmitter with an integer baud divider.
//            Define UART_TX_PARITY_EN to insert an even-parity bit.
// Revision : 1.0  initial release
// ============================================================================
module uart_tx_queue #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 16
) (
    input  wire logic        clk,
    input  wire logic        reset,
    uart_tx_queue_if.slave   bus
);

    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [LW-1:0] C_FULL_LEVEL = LW'(DEPTH);
    localparam logic [CW-1:0] C_BIT_LAST   = CW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } state_t;

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;
    logic          r_tx;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
`ifdef UART_TX_PARITY_EN
    logic          r_parity;
`endif

    state_t        w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic [2:0]    w_idx_next;
    logic [7:0]    w_shift_next;
    logic          w_tx_next;
    logic          w_pop;
    logic          w_accept;
    logic          w_full;
    logic          w_empty;
    logic          w_bit_last;

    assign w_full     = (r_level == C_FULL_LEVEL);
    assign w_empty    = (r_level == '0);
    assign w_accept   = bus.wen && !w_full;
    assign w_bit_last = (r_cnt == C_BIT_LAST);

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.level    = r_level;
    assign bus.overflow = r_overflow;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.tx       = r_tx;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wptr] <= bus.wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (bus.wen && w_full) begin
                r_overflow <= 1'b1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serializer state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_idx   <= w_idx_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^r_mem[r_rptr];
        end
    end
`endif

    // ------------------------------------------------------------------
    // Serializer next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_pop        = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                    w_shift_next = r_mem[r_rptr];
                end
            end

            S_START: begin
                if (w_bit_last) begin
                    w_state_next = S_DATA;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (w_bit_last) begin
                    w_cnt_next   = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_idx_next = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_last) begin
                    w_state_next = S_STOP;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
`endif

            S_STOP: begin
                if (w_bit_last) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Line level is registered, so tx trails the state by one clock.
    always_comb begin
        w_tx_next = 1'b1;
        case (r_state)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
// Bench for uart_tx_queue: directed scenarios plus random traffic, checked
// every cycle against a frame-timing model of the queue and the line.
module tb_uart_tx_queue;

    localparam int CLK_HZ = 8;
    localparam int BAUD   = 1;
    localparam int DEPTH  = 4;
    localparam int DIV    = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME  = 11 * DIV;
`else
    localparam int FRAME  = 10 * DIV;
`endif

    logic clk;
    logic reset;

    uart_tx_queue_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_queue #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .DEPTH  (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: byte queue plus remaining cycles of the frame on the wire.
    logic [7:0] mq[$];
    int         m_rem  = 0;
    logic [7:0] m_byte = 8'h00;
    logic       m_tx   = 1'b1;
    logic       m_ovf  = 1'b0;

    function automatic logic frame_bit(input logic [7:0] b, input int pos);
        if (pos == 0) return 1'b0;
        if (pos <= 8) return b[pos-1];
`ifdef UART_TX_PARITY_EN
        if (pos == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst_n, input logic w, input logic [7:0] d);
        logic was_full;
        if (!rst_n) begin
            mq.delete();
            m_rem = 0;
            m_tx  = 1'b1;
            m_ovf = 1'b0;
        end else begin
            was_full = (mq.size() == DEPTH);
            m_tx = (m_rem > 0) ? frame_bit(m_byte, (FRAME - m_rem) / DIV) : 1'b1;
            if (m_rem > 0) begin
                m_rem--;
            end else if (mq.size() > 0) begin
                m_byte = mq.pop_front();
                m_rem  = FRAME;
            end
            if (w) begin
                if (was_full) m_ovf = 1'b1;
                else          mq.push_back(d);
            end
        end
    endtask

    task automatic tick(input logic rst_n, input logic w, input logic [7:0] d);
        reset     = rst_n;
        bus.wen   = w;
        bus.wdata = d;
        @(posedge clk);
        cyc++;
        model_edge(rst_n, w, d);
        #1;
        chk("tx",       bus.tx,       m_tx);
        chk("busy",     bus.busy,     (m_rem > 0));
        chk("level",    bus.level,    mq.size());
        chk("full",     bus.full,     (mq.size() == DEPTH));
        chk("empty",    bus.empty,    (mq.size() == 0));
        chk("overflow", bus.overflow, m_ovf);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        int busy_cnt;
        reset     = 1'b0;
        bus.wen   = 1'b0;
        bus.wdata = 8'h00;

        // Reset state
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'hFF);
        chk("rst_tx",    bus.tx,       1);
        chk("rst_busy",  bus.busy,     0);
        chk("rst_empty", bus.empty,    1);
        chk("rst_level", bus.level,    0);
        chk("rst_ovf",   bus.overflow, 0);
        idle(3);

        // Single byte 0x55: busy spans exactly one frame
        tick(1'b1, 1'b1, 8'h55);
        busy_cnt = 0;
        for (int i = 0; i < FRAME + 20; i++) begin
            tick(1'b1, 1'b0, 8'h00);
            if (bus.busy === 1'b1) busy_cnt++;
        end
        chk("busy_len", busy_cnt, FRAME);

        // Burst of three: level peaks at 2
        tick(1'b1, 1'b1, 8'h01);
        tick(1'b1, 1'b1, 8'h02);
        tick(1'b1, 1'b1, 8'h03);
        chk("burst_peak", bus.level, 2);
        idle(3 * (FRAME + 1) + 10);

        // Push coinciding with pop keeps level at 1
        tick(1'b1, 1'b1, 8'h3C);
        tick(1'b1, 1'b1, 8'hC3);
        chk("pushpop_level", bus.level, 1);
        idle(2 * (FRAME + 1) + 10);

        // Overflow: A0 in flight, A1..A4 queued, A5 dropped
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b1, 8'hA0 + 8'(i));
            if (i == 4) chk("ovf_full", bus.full, 1);
        end
        chk("ovf_set", bus.overflow, 1);
        idle(5 * (FRAME + 1) + 10);
        chk("ovf_sticky", bus.overflow, 1);
        chk("ovf_drained", bus.empty, 1);

        // Reset during data bit 3 with two bytes queued
        tick(1'b1, 1'b1, 8'h96);
        tick(1'b1, 1'b1, 8'h5A);
        tick(1'b1, 1'b1, 8'hE1);
        idle(34);
        tick(1'b0, 1'b0, 8'h00);
        chk("midrst_tx",    bus.tx,    1);
        chk("midrst_level", bus.level, 0);
        chk("midrst_busy",  bus.busy,  0);
        idle(FRAME + 20);

        // Parity-sensitive bytes
        tick(1'b1, 1'b1, 8'h07);
        idle(FRAME + 5);
        tick(1'b1, 1'b1, 8'h03);
        idle(FRAME + 5);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 999) != 0),
                 ($urandom_range(0, 15) == 0),
                 8'($urandom));
        end
        idle(DEPTH * (FRAME + 1) + FRAME + 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
